// File: rtl/cpu_core.sv
// -----------------------------------------------------------------------------
// cpu_core: multi-cycle 16-bit load/store processor.
//
// Instructions are fetched from a unified 512 x 16 instruction/data memory,
// starting at PC=0 after a start pulse. Each instruction runs FETCH, EXEC, WB,
// DONE (4 cycles). Execution stops on HALT and the core returns to IDLE.
// The register file has four 16-bit registers. x0 reads as zero.
//
// Ports:
//   clk    in   single clock, rising-edge
//   reset  in   asynchronous, active-high; aborts any instruction in flight
//   start  in   begin execution at PC=0 (sampled only in IDLE)
//   ready  out  one-cycle pulse per retired instruction
//
// Hierarchy used for preloading (names are fixed):
//   MEM.memory[0:511]  unified instruction/data memory
//   RF.x0 .. RF.x3     register file
//
// Configuration macro:
//   CPU_MULDIV_EN  defined   -> MUL/DIV hardware is built
//                  undefined -> opcodes MUL/DIV write 16'h0000 to rd
//
// ready is registered out of DONE. Its rising edge therefore lands 4 clocks
// after the edge that starts the instruction's FETCH. By then the WB write
// (register or memory) is already visible.
// -----------------------------------------------------------------------------

module cpu_mem (
    input  logic        clk,
    input  logic        we,
    input  logic [8:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [8:0]  raddr,
    output logic [15:0] rdata
);
    logic [15:0] memory [0:511];

    always_ff @(posedge clk) begin
        if (we) memory[waddr] <= wdata;
    end

    // Combinational read port.
    assign rdata = memory[raddr];
endmodule

module cpu_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [1:0]  wa,
    input  logic [15:0] wd,
    input  logic [1:0]  ra1,
    input  logic [1:0]  ra2,
    input  logic [1:0]  ra3,
    output logic [15:0] rd1,
    output logic [15:0] rd2,
    output logic [15:0] rd3
);
    logic [15:0] x0, x1, x2, x3;

    // x0 is forced to zero every clock, so writes to it are discarded.
    always_ff @(posedge clk) begin
        x0 <= '0;
        if (we && wa == 2'd1) x1 <= wd;
        if (we && wa == 2'd2) x2 <= wd;
        if (we && wa == 2'd3) x3 <= wd;
    end

    function automatic logic [15:0] sel(input logic [1:0] a);
        case (a)
            2'd1:    return x1;
            2'd2:    return x2;
            2'd3:    return x3;
            default: return x0;
        endcase
    endfunction

    assign rd1 = sel(ra1);
    assign rd2 = sel(ra2);
    assign rd3 = sel(ra3);
endmodule

module cpu_core (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic ready
);
    localparam int DATA_W = 16;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_MUL   = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_STORE = 3'b101;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        WB    = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state;
    logic [8:0]          pc;
    logic [DATA_W-1:0]   ir;
    logic [DATA_W-1:0]   result;
    logic [DATA_W-1:0]   alu;
    logic [DATA_W-1:0]   mem_rdata;
    logic [DATA_W-1:0]   rs1_val, rs2_val, rd_val;
    logic signed [DATA_W-1:0] a, b;

    logic [2:0]  op;
    logic [1:0]  rd, rs1, rs2;
    logic [15:0] imm;

    assign op  = ir[15:13];
    assign rd  = ir[12:11];
    assign rs1 = ir[10:9];
    assign rs2 = ir[8:7];
    assign imm = {7'd0, ir[8:0]};

    logic rf_we, mem_we;
    assign rf_we  = (state == WB) &&
                    (op == OP_ADD || op == OP_SUB || op == OP_MUL ||
                     op == OP_DIV || op == OP_LOAD);
    assign mem_we = (state == WB) && (op == OP_STORE);

    // Single read port: instruction address during FETCH, effective address otherwise.
    cpu_mem MEM (
        .clk   (clk),
        .we    (mem_we),
        .waddr (result[8:0]),
        .wdata (rd_val),
        .raddr ((state == FETCH) ? pc : result[8:0]),
        .rdata (mem_rdata)
    );

    // rd doubles as the source-register port for STORE.
    cpu_regfile RF (
        .clk (clk),
        .we  (rf_we),
        .wa  (rd),
        .wd  ((op == OP_LOAD) ? mem_rdata : result),
        .ra1 (rs1),
        .ra2 (rs2),
        .ra3 (rd),
        .rd1 (rs1_val),
        .rd2 (rs2_val),
        .rd3 (rd_val)
    );

    assign a = $signed(rs1_val);
    assign b = $signed(rs2_val);

`ifdef CPU_MULDIV_EN
    function automatic logic [DATA_W-1:0] mul_lo(input logic signed [DATA_W-1:0] x,
                                                 input logic signed [DATA_W-1:0] y);
        logic signed [2*DATA_W-1:0] p;
        p = 32'(x) * 32'(y);
        return p[DATA_W-1:0];
    endfunction

    // Truncating signed divide. Divide-by-zero yields all ones. The one
    // overflowing quotient (-32768 / -1) wraps to 16'h8000.
    function automatic logic [DATA_W-1:0] div_trunc(input logic signed [DATA_W-1:0] x,
                                                    input logic signed [DATA_W-1:0] y);
        if (y == 16'sh0000) return 16'hFFFF;
        if (x == 16'sh8000 && y == 16'shFFFF) return 16'h8000;
        return x / y;
    endfunction
`endif

    always_comb begin
        alu = '0;
        case (op)
            OP_ADD:            alu = a + b;
            OP_SUB:            alu = a - b;
`ifdef CPU_MULDIV_EN
            OP_MUL:            alu = mul_lo(a, b);
            OP_DIV:            alu = div_trunc(a, b);
`else
            OP_MUL, OP_DIV:    alu = '0;
`endif
            OP_LOAD, OP_STORE: alu = rs1_val + imm;
            default:           alu = '0;
        endcase
    end

    // EXEC -> WB boundary: ALU result or effective address.
    always_ff @(posedge clk) begin
        if (state == EXEC) result <= alu;
    end

    // Control FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc    <= '0;
            ir    <= '0;
            ready <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pc    <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    ir    <= mem_rdata;
                    pc    <= pc + 9'd1;
                    state <= EXEC;
                end
                EXEC:    state <= WB;
                WB:      state <= DONE;
                DONE: begin
                    ready <= 1'b1;
                    state <= (op == OP_HALT) ? IDLE : FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_core.sv
`timescale 1ns/1ps
module tb_cpu_core;
    logic clk = 1'b0;
    logic reset;
    logic start;
    logic ready;

    cpu_core dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .ready (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0: register, 1: memory word, 2: retire only
        int          idx;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   last_cyc = 0;
    bit   first_pulse = 1'b0;
    int   pulses = 0;
    logic prev_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] get_reg(input int i);
        case (i)
            0:       return dut.RF.x0;
            1:       return dut.RF.x1;
            2:       return dut.RF.x2;
            default: return dut.RF.x3;
        endcase
    endfunction

    function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [1:0] rd,
                                          input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, rd, rs1, rs2, 7'd0};
    endfunction

    function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [1:0] rd,
                                          input logic [1:0] rs1, input logic [8:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    task automatic exp_push(input int kind, input int idx, input logic [15:0] val, input string name);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        e.name = name;
        q.push_back(e);
    endtask

    // Monitor: on every ready pulse, check spacing/width and pop one expectation.
    always @(negedge clk) begin
        if (ready) begin
            pulses++;
            check_int("ready_width", int'(prev_ready), 0);
            if (first_pulse) check_int("cadence_first", cyc - start_cyc, 4);
            else             check_int("cadence", cyc - last_cyc, 4);
            first_pulse = 1'b0;
            last_cyc    = cyc;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got pulse at cycle %0d expected none", cyc);
            end else begin
                mon_e = q.pop_front();
                case (mon_e.kind)
                    0:       check(mon_e.name, get_reg(mon_e.idx), mon_e.val);
                    1:       check(mon_e.name, dut.MEM.memory[mon_e.idx], mon_e.val);
                    default: ;
                endcase
            end
        end
        prev_ready = ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_prog();
        start = 1'b1;
        tick();
        start_cyc   = cyc;
        first_pulse = 1'b1;
        start       = 1'b0;
    endtask

    task automatic run_and_wait(input string tag);
        int n;
        start_prog();
        for (int i = 0; i < 300 && q.size() > 0; i++) tick();
        check_int({tag, "_drain"}, q.size(), 0);
        q.delete();
        n = pulses;
        repeat (10) tick();
        check_int({tag, "_no_more_ready"}, pulses, n);
        check_int({tag, "_idle"}, int'(dut.state), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        repeat (2) tick();
        check("reset_ready", {15'd0, ready}, 16'h0000);
        check("reset_pc", {7'd0, dut.pc}, 16'h0000);
        check("reset_ir", dut.ir, 16'h0000);
        check_int("reset_state", int'(dut.state), 0);
        reset = 1'b0;
        tick();

        // Reference program.
        for (int i = 0; i < 64; i++) dut.MEM.memory[i] = 16'h0000;
        dut.MEM.memory[0]  = enc_r(3'b000, 2'd1, 2'd2, 2'd3);
        dut.MEM.memory[1]  = enc_r(3'b001, 2'd1, 2'd1, 2'd3);
        dut.MEM.memory[2]  = enc_r(3'b010, 2'd2, 2'd1, 2'd3);
        dut.MEM.memory[3]  = enc_r(3'b011, 2'd3, 2'd2, 2'd1);
        dut.MEM.memory[4]  = enc_i(3'b101, 2'd1, 2'd0, 9'd10);
        dut.MEM.memory[5]  = enc_i(3'b100, 2'd3, 2'd0, 9'd10);
        dut.MEM.memory[6]  = enc_r(3'b000, 2'd1, 2'd3, 2'd2);
        dut.MEM.memory[7]  = enc_i(3'b101, 2'd2, 2'd0, 9'd12);
        dut.MEM.memory[8]  = 16'hE000;
        dut.MEM.memory[10] = 16'd123;
        dut.MEM.memory[12] = 16'h0000;
        dut.RF.x1 = 16'h0000;
        dut.RF.x2 = 16'd7;
        dut.RF.x3 = 16'hFFFD;
        exp_push(0, 1, 16'h0004, "ref_add");
        exp_push(0, 1, 16'h0007, "ref_sub");
`ifdef CPU_MULDIV_EN
        exp_push(0, 2, 16'hFFEB, "ref_mul");
        exp_push(0, 3, 16'hFFFD, "ref_div");
`else
        exp_push(0, 2, 16'h0000, "ref_mul_off");
        exp_push(0, 3, 16'h0000, "ref_div_off");
`endif
        exp_push(1, 10, 16'h0007, "ref_store10");
        exp_push(0, 3, 16'h0007, "ref_load");
`ifdef CPU_MULDIV_EN
        exp_push(0, 1, 16'hFFF2, "ref_add2");
        exp_push(1, 12, 16'hFFEB, "ref_store12");
`else
        exp_push(0, 1, 16'h0007, "ref_add2");
        exp_push(1, 12, 16'h0000, "ref_store12");
`endif
        exp_push(2, 0, 16'h0000, "ref_halt");
        run_and_wait("ref");

        // x0 write discarded, then HALT.
        dut.MEM.memory[0] = enc_r(3'b000, 2'd0, 2'd2, 2'd3);
        dut.MEM.memory[1] = 16'hE000;
        exp_push(0, 0, 16'h0000, "x0_stays_zero");
        exp_push(2, 0, 16'h0000, "x0_halt");
        run_and_wait("x0");

        // Divide edge cases.
        dut.MEM.memory[20] = 16'hFFF9;
        dut.MEM.memory[21] = 16'h0002;
        dut.MEM.memory[22] = 16'h8000;
        dut.MEM.memory[23] = 16'hFFFF;
        dut.MEM.memory[0]  = enc_i(3'b100, 2'd1, 2'd0, 9'd20);
        dut.MEM.memory[1]  = enc_i(3'b100, 2'd2, 2'd0, 9'd21);
        dut.MEM.memory[2]  = enc_r(3'b011, 2'd3, 2'd1, 2'd0);
        dut.MEM.memory[3]  = enc_r(3'b011, 2'd3, 2'd1, 2'd2);
        dut.MEM.memory[4]  = enc_i(3'b100, 2'd1, 2'd0, 9'd22);
        dut.MEM.memory[5]  = enc_i(3'b100, 2'd2, 2'd0, 9'd23);
        dut.MEM.memory[6]  = enc_r(3'b011, 2'd3, 2'd1, 2'd2);
        dut.MEM.memory[7]  = 16'hC000;
        dut.MEM.memory[8]  = 16'hE000;
        exp_push(0, 1, 16'hFFF9, "div_ld_a");
        exp_push(0, 2, 16'h0002, "div_ld_b");
`ifdef CPU_MULDIV_EN
        exp_push(0, 3, 16'hFFFF, "div_by_zero");
        exp_push(0, 3, 16'hFFFD, "div_neg7_by_2");
`else
        exp_push(0, 3, 16'h0000, "div_by_zero_off");
        exp_push(0, 3, 16'h0000, "div_neg7_by_2_off");
`endif
        exp_push(0, 1, 16'h8000, "div_ld_c");
        exp_push(0, 2, 16'hFFFF, "div_ld_d");
`ifdef CPU_MULDIV_EN
        exp_push(0, 3, 16'h8000, "div_min_by_neg1");
`else
        exp_push(0, 3, 16'h0000, "div_min_by_neg1_off");
`endif
        exp_push(2, 0, 16'h0000, "div_nop");
        exp_push(2, 0, 16'h0000, "div_halt");
        run_and_wait("div");

        // Reset asserted during the WB cycle of a STORE.
        dut.MEM.memory[30] = 16'h1234;
        dut.MEM.memory[0]  = enc_i(3'b101, 2'd1, 2'd0, 9'd30);
        dut.MEM.memory[1]  = 16'hE000;
        n = pulses;
        start_prog();
        tick();
        tick();
        check_int("abort_in_wb", int'(dut.state), 3);
        reset = 1'b1;
        #1;
        check("abort_ready", {15'd0, ready}, 16'h0000);
        check_int("abort_state", int'(dut.state), 0);
        tick();
        tick();
        reset = 1'b0;
        repeat (12) tick();
        check("abort_mem30", dut.MEM.memory[30], 16'h1234);
        check_int("abort_no_ready", pulses, n);
        check("abort_x1_kept", dut.RF.x1, 16'h8000);
        check("abort_x2_kept", dut.RF.x2, 16'hFFFF);
        check("abort_pc", {7'd0, dut.pc}, 16'h0000);
        check_int("abort_idle", int'(dut.state), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
